dct_da_accumulator: RTL and testbench

Bit-serial distributed-arithmetic (DA) engine for one DCT output term. It accepts four signed input samples and sequences their bit-planes MSB-first into the 4-bit address of the coefficient ROM (`ROM2_Z0`-class, 17-bit unsigned Q3.14 partial sums of c4). It shift-accumulates the returned ROM words into a signed result. It sits between the DCT input butterfly and the ROM, driving the ROM's `addr`/`cs` and consuming its `data`.

---
 rtl/dct_da_accumulator.sv | 182 ++++++++++++++++++
 tb/tb_dct_da_accumulator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_da_accumulator.sv
// ----------------------------------------------------------------------------
// dct_da_accumulator
//
// Bit-serial distributed-arithmetic engine for one DCT output term.  Four
// signed samples are captured into shift registers and presented to the c4
// partial-sum ROM one bit-plane at a time, MSB (sign plane) first.  The
// unsigned ROM words are shift-accumulated into an exact signed result.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   in_valid   : x0..x3 hold a valid sample set
//   in_ready   : block can accept a new sample set (combinational in DONE)
//   x0..x3     : signed IN_W-bit samples
//   rom_cs     : ROM chip select, high only while bit-planes are sequenced
//   rom_addr   : {x3[b], x2[b], x1[b], x0[b]} for the current bit-plane b
//   rom_data   : unsigned ROM_W-bit word, combinational from rom_addr
//   out_valid  : dout holds a completed result
//   out_ready  : consumer accepts dout
//   dout       : signed OUT_W-bit result
//
// Build option
//   DCT_DA_ROUND_EN : when defined, dout is the accumulated value rounded
//                     half-up to an integer (acc + 2^(FRAC-1)) >>> FRAC.
//                     When undefined, dout is the raw fixed-point sum.
// ----------------------------------------------------------------------------
module dct_da_accumulator #(
    parameter int IN_W  = 12,
    parameter int ROM_W = 17,
    parameter int FRAC  = 14,
    parameter int OUT_W = IN_W + ROM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x0,
    input  logic signed [IN_W-1:0]  x1,
    input  logic signed [IN_W-1:0]  x2,
    input  logic signed [IN_W-1:0]  x3,
    output logic                    rom_cs,
    output logic [3:0]              rom_addr,
    input  logic [ROM_W-1:0]        rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] dout
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [IN_W-1:0]         sh0;
    logic [IN_W-1:0]         sh1;
    logic [IN_W-1:0]         sh2;
    logic [IN_W-1:0]         sh3;
    logic [CNT_W-1:0]        cnt;
    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] acc_next;
    logic signed [OUT_W-1:0] rom_ext;
    logic signed [OUT_W-1:0] dout_next;
    logic signed [OUT_W-1:0] dout_r;
    logic                    out_valid_r;
    logic                    rom_cs_r;
    logic                    first_plane;
    logic                    last_plane;

    // A new set can be taken when idle, or while the finished result is
    // being handed off in the same cycle, which allows back-to-back runs.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    // The counter is loaded with the sign-plane index, so the first RUN
    // cycle is recognised by the counter still sitting at its top value.
    assign first_plane = (cnt == CNT_TOP);
    assign last_plane  = (cnt == '0);

    // ROM words are unsigned.  Every legal c4 partial sum (at most 4*c4)
    // leaves the ROM MSB clear, so zero- and sign-extension coincide here.
    assign rom_ext = {{(OUT_W - ROM_W){1'b0}}, rom_data};

    // MSB-first accumulation: the sign plane carries negative weight, every
    // later plane doubles the running sum and adds its word.
    assign acc_next = first_plane ? -rom_ext : ((acc <<< 1) + rom_ext);

`ifdef DCT_DA_ROUND_EN
    // Adding one half before the arithmetic shift rounds ties toward +inf.
    localparam logic signed [OUT_W-1:0] HALF =
        {{(OUT_W - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    logic signed [OUT_W-1:0] rounded_sum;
    assign rounded_sum = acc_next + HALF;
    assign dout_next   = rounded_sum >>> FRAC;
`else
    assign dout_next = acc_next;
`endif

    // The address is the current MSB column of the four shift registers,
    // forced to zero whenever the ROM is not selected.
    assign rom_addr  = rom_cs_r ? {sh3[IN_W-1], sh2[IN_W-1], sh1[IN_W-1], sh0[IN_W-1]}
                                : 4'b0000;
    assign rom_cs    = rom_cs_r;
    assign out_valid = out_valid_r;
    assign dout      = dout_r;

    // Control FSM and datapath.  Loading happens from IDLE, or from DONE
    // in the same edge that the previous result is accepted.  RUN sequences
    // IN_W planes; the result is registered on the b=0 edge and held in
    // DONE until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            sh3         <= '0;
            cnt         <= '0;
            acc         <= '0;
            dout_r      <= '0;
            out_valid_r <= 1'b0;
            rom_cs_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh0      <= x0;
                        sh1      <= x1;
                        sh2      <= x2;
                        sh3      <= x3;
                        cnt      <= CNT_TOP;
                        rom_cs_r <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    sh0 <= {sh0[IN_W-2:0], 1'b0};
                    sh1 <= {sh1[IN_W-2:0], 1'b0};
                    sh2 <= {sh2[IN_W-2:0], 1'b0};
                    sh3 <= {sh3[IN_W-2:0], 1'b0};
                    acc <= acc_next;
                    if (last_plane) begin
                        dout_r      <= dout_next;
                        out_valid_r <= 1'b1;
                        rom_cs_r    <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            sh0      <= x0;
                            sh1      <= x1;
                            sh2      <= x2;
                            sh3      <= x3;
                            cnt      <= CNT_TOP;
                            rom_cs_r <= 1'b1;
                            state    <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    rom_cs_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_da_accumulator.sv
// ----------------------------------------------------------------------------
// tb_dct_da_accumulator
//
// Self-checking bench for dct_da_accumulator.  Provides a c4 partial-sum ROM
// model (word = popcount(addr) * 11585, zero in the first cycle after reset),
// a scoreboard of expected results pushed at each load handshake and popped
// at each output handshake, and a directed sequence of scenarios.
// Honours DCT_DA_ROUND_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_dct_da_accumulator;

    localparam int IN_W  = 12;
    localparam int ROM_W = 17;
    localparam int FRAC  = 14;
    localparam int OUT_W = IN_W + ROM_W;
    localparam int C4    = 11585;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  x0;
    logic signed [IN_W-1:0]  x1;
    logic signed [IN_W-1:0]  x2;
    logic signed [IN_W-1:0]  x3;
    logic                    rom_cs;
    logic [3:0]              rom_addr;
    logic [ROM_W-1:0]        rom_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] dout;

    int     n_assert = 0;
    int     n_fail   = 0;
    int     n_out    = 0;
    int     cyc      = 0;
    longint sb[$];
    int     out_cyc[$];
    logic   rom_awake;

    always #5 clk = ~clk;

    dct_da_accumulator #(
        .IN_W (IN_W),
        .ROM_W(ROM_W),
        .FRAC (FRAC),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x0       (x0),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout)
    );

    // ROM model: returns 0 for the first cycle after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rom_awake <= 1'b0;
        else        rom_awake <= 1'b1;
    end

    always_comb begin
        rom_data = '0;
        if (rom_awake)
            rom_data = ROM_W'(C4 * (int'(rom_addr[0]) + int'(rom_addr[1]) +
                                    int'(rom_addr[2]) + int'(rom_addr[3])));
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic signed [63:0] obs,
                                input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model(input int a, input int b, input int c, input int d);
        longint acc;
        acc = longint'(C4) * longint'(a + b + c + d);
`ifdef DCT_DA_ROUND_EN
        return (acc + 64'sd8192) >>> FRAC;
`else
        return acc;
`endif
    endfunction

    // Output monitor: a handshake seen at the falling edge completes on the
    // next rising edge, so the oldest expectation is compared here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_output("sb_nonempty", 64'(sb.size() != 0), 64'sd1);
            if (sb.size() != 0) check_output("dout", dout, sb.pop_front());
            out_cyc.push_back(cyc);
            n_out++;
        end
    end

    // Called #1 after a rising edge.  Drives a set with in_valid high and
    // waits for acceptance; returns #1 after the load edge with in_valid
    // still asserted.
    task automatic apply_stimulus(input int a, input int b, input int c, input int d);
        bit ok = 1'b0;
        x0 = IN_W'(a);
        x1 = IN_W'(b);
        x2 = IN_W'(c);
        x3 = IN_W'(d);
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("load_timeout", 64'(ok), 64'sd1);
        if (ok) sb.push_back(model(a, b, c, d));
        @(posedge clk);
        #1;
    endtask

    // Checks the address sequence of all IN_W planes, MSB first, then that
    // out_valid rises exactly after the last plane.
    task automatic check_planes(input int a, input int b, input int c, input int d);
        logic [IN_W-1:0] va = IN_W'(a);
        logic [IN_W-1:0] vb = IN_W'(b);
        logic [IN_W-1:0] vc = IN_W'(c);
        logic [IN_W-1:0] vd = IN_W'(d);
        for (int p = IN_W - 1; p >= 0; p--) begin
            @(negedge clk);
            check_output("rom_cs_run", 64'(rom_cs), 64'sd1);
            check_output("rom_addr", 64'(rom_addr), 64'({vd[p], vc[p], vb[p], va[p]}));
            check_output("out_valid_early", 64'(out_valid), 64'sd0);
        end
        @(negedge clk);
        check_output("out_valid_latency", 64'(out_valid), 64'sd1);
        check_output("rom_cs_done", 64'(rom_cs), 64'sd0);
        check_output("rom_addr_done", 64'(rom_addr), 64'sd0);
    endtask

    // Waits (bounded) for out_valid, then lets the next rising edge pass.
    task automatic wait_result();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("result_timeout", 64'(ok), 64'sd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [OUT_W-1:0] held;
        int base;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 64'(out_valid), 64'sd0);
        check_output("rst_dout", dout, 64'sd0);
        check_output("rst_rom_cs", 64'(rom_cs), 64'sd0);
        check_output("rst_rom_addr", 64'(rom_addr), 64'sd0);
        check_output("rst_in_ready", 64'(in_ready), 64'sd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: all ones, addr 0000 for 11 planes then 1111.
        $display("[TB] all ones");
        apply_stimulus(1, 1, 1, 1);
        in_valid = 1'b0;
        check_planes(1, 1, 1, 1);
        @(posedge clk);
        #1;
        check_output("idle_in_ready", 64'(in_ready), 64'sd1);

        // 2: single negative, addr 0001 on every plane.
        $display("[TB] single negative");
        apply_stimulus(-1, 0, 0, 0);
        in_valid = 1'b0;
        check_planes(-1, 0, 0, 0);
        @(posedge clk);
        #1;

        // 3: all minimum, only the sign plane addresses 1111.
        $display("[TB] all minimum");
        apply_stimulus(-2048, -2048, -2048, -2048);
        in_valid = 1'b0;
        check_planes(-2048, -2048, -2048, -2048);
        @(posedge clk);
        #1;

        // 4: backpressure with a pending new set.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        apply_stimulus(3, -5, 7, 100);
        in_valid = 1'b0;
        wait_result();
        held = dout;
        x0 = 12'sd5; x1 = 12'sd6; x2 = -12'sd7; x3 = 12'sd8;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_out_valid", 64'(out_valid), 64'sd1);
            check_output("bp_in_ready", 64'(in_ready), 64'sd0);
            check_output("bp_dout_stable", dout, held);
            check_output("bp_rom_cs", 64'(rom_cs), 64'sd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_release_in_ready", 64'(in_ready), 64'sd1);
        sb.push_back(model(5, 6, -7, 8));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_output("bp_same_edge_load", 64'(rom_cs), 64'sd1);
        check_output("bp_out_valid_clear", 64'(out_valid), 64'sd0);
        wait_result();

        // 5: reset at plane b=5, then a fresh transaction.
        $display("[TB] mid-run reset");
        apply_stimulus(1, 2, 3, 4);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        check_output("mr_running", 64'(rom_cs), 64'sd1);
        rst_n = 1'b0;
        #1;
        check_output("mr_out_valid", 64'(out_valid), 64'sd0);
        check_output("mr_dout", dout, 64'sd0);
        check_output("mr_rom_cs", 64'(rom_cs), 64'sd0);
        check_output("mr_rom_addr", 64'(rom_addr), 64'sd0);
        check_output("mr_in_ready", 64'(in_ready), 64'sd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1, 0, 0, 0);
        in_valid = 1'b0;
        wait_result();

        // 6: three back-to-back transactions, results every 13 cycles.
        $display("[TB] back-to-back");
        base = out_cyc.size();
        apply_stimulus(100, -200, 300, -400);
        apply_stimulus(2047, 2047, 2047, 2047);
        apply_stimulus(-7, 13, -1024, 512);
        in_valid = 1'b0;
        wait_result();
        check_output("b2b_count", 64'(out_cyc.size() - base), 64'sd3);
        if (out_cyc.size() - base == 3) begin
            check_output("b2b_spacing_1", 64'(out_cyc[base+1] - out_cyc[base]), 64'(IN_W + 1));
            check_output("b2b_spacing_2", 64'(out_cyc[base+2] - out_cyc[base+1]), 64'(IN_W + 1));
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("sb_drained", 64'(sb.size()), 64'sd0);
        check_output("total_results", 64'(n_out), 64'sd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
